// File: rtl/rs232_uart_pkg.sv
// Shared constants, helpers and FSM encodings for the 8N1 RS-232 transceiver.
// DIV is the clock count per bit; HALF places the start-bit check mid-bit.
package rs232_uart_pkg;

    localparam int unsigned DEF_CLK_HZ = 50_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;
    localparam int unsigned FRAME_BITS = 10;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned calc_half(input int unsigned div);
        return div / 2;
    endfunction

    // Bit counter runs 0..DIV-1; keep at least one bit for degenerate rates.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/rs232_uart_if.sv
// CPU-facing handshake of the transceiver: RX holding register and TX request/status.
// rx/tx modports give each half of the design only the signals it owns.
interface rs232_uart_if;

    logic       readRX;
    logic       charReady;
    logic [7:0] RXchar;
    logic       writeTX;
    logic [7:0] TXchar;
    logic       TXempty;

    modport master (
        output readRX, writeTX, TXchar,
        input  charReady, RXchar, TXempty
    );

    modport slave (
        input  readRX, writeTX, TXchar,
        output charReady, RXchar, TXempty
    );

    modport rx (
        input  readRX,
        output charReady, RXchar
    );

    modport tx (
        input  writeTX, TXchar,
        output TXempty
    );

endinterface

// File: rtl/rs232_rx.sv
// 8N1 receiver: two-flop synchroniser, mid-bit sampling FSM and one-character holding register.
// Framing errors drop the byte and wait for the line to return high before re-arming.
module rs232_rx
    import rs232_uart_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     RxD,
    rs232_uart_if.rx bus
);

    localparam int unsigned HALF = calc_half(DIV);
    localparam int unsigned CW   = cnt_width(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic          r_meta;
    logic          r_sync;
    rx_state_t     r_state;
    rx_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic [7:0]    r_char;
    logic [7:0]    w_char_next;
    logic          r_ready;
    logic          w_ready_next;
    logic          w_bit_end;

    // Synchroniser resets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_char  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_meta  <= RxD;
            r_sync  <= r_meta;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_char  <= w_char_next;
            r_ready <= w_ready_next;
        end
    end

    assign w_bit_end = (r_cnt == BIT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_char_next  = r_char;
        // A delivery later in this block overrides a simultaneous read.
        w_ready_next = r_ready & ~bus.readRX;

        case (r_state)
            RX_IDLE: begin
                if (!r_sync) begin
                    w_state_next = RX_START;
                    w_cnt_next   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    if (!r_sync) begin
                        w_state_next = RX_DATA;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next = RX_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next          = '0;
                    w_shift_next[r_idx] = r_sync;
                    if (r_idx == 3'd7) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_sync) begin
                        w_char_next  = r_shift;
                        w_ready_next = 1'b1;
                        w_state_next = RX_IDLE;
                    end else begin
                        w_state_next = RX_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                if (r_sync) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.charReady = r_ready;
    assign bus.RXchar    = r_char;

endmodule

// File: rtl/rs232_tx.sv
// 8N1 transmitter: start bit, eight data bits LSB first, stop bit, each held DIV clocks.
// TXempty rises the cycle after the stop bit completes, so an immediate rewrite leaves no idle gap.
module rs232_tx
    import rs232_uart_pkg::*;
#(
    parameter int unsigned DIV = 434
) (
    input  logic     clock,
    input  logic     reset,
    output logic     TxD,
    rs232_uart_if.tx bus
);

    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
    localparam logic [3:0]    FRAME_LAST = 4'(FRAME_BITS - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [3:0]    r_bit;
    logic [3:0]    w_bit_next;
    logic [8:0]    r_frame;
    logic [8:0]    w_frame_next;
    logic          r_txd;
    logic          w_txd_next;
    logic          r_empty;
    logic          w_empty_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_frame <= '1;
            r_txd   <= 1'b1;
            r_empty <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_frame <= w_frame_next;
            r_txd   <= w_txd_next;
            r_empty <= w_empty_next;
        end
    end

    // r_frame holds the bits still to go ({stop, data}); the start bit goes straight to r_txd.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_frame_next = r_frame;
        w_txd_next   = r_txd;
        w_empty_next = r_empty;

        case (r_state)
            TX_IDLE: begin
                if (bus.writeTX) begin
                    w_frame_next = {1'b1, bus.TXchar};
                    w_txd_next   = 1'b0;
                    w_empty_next = 1'b0;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == FRAME_LAST) begin
                        w_txd_next   = 1'b1;
                        w_empty_next = 1'b1;
                        w_state_next = TX_IDLE;
                    end else begin
                        w_bit_next   = r_bit + 4'd1;
                        w_txd_next   = r_frame[0];
                        w_frame_next = {1'b1, r_frame[8:1]};
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = TX_IDLE;
                w_txd_next   = 1'b1;
                w_empty_next = 1'b1;
            end
        endcase
    end

    assign TxD         = r_txd;
    assign bus.TXempty = r_empty;

endmodule

// File: rtl/rs232_uart.sv
// TinyComp RS-232 device (RX = device 0, TX = device 1) with the legacy flat port list.
// Only wires the independent receiver and transmitter through the internal handshake bundle.
module rs232_uart
    import rs232_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RxD,
    input  logic       readRX,
    output logic       charReady,
    output logic [7:0] RXchar,
    input  logic       writeTX,
    input  logic [7:0] TXchar,
    output logic       TXempty,
    output logic       TxD
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

    rs232_uart_if w_bus ();

    assign w_bus.readRX  = readRX;
    assign w_bus.writeTX = writeTX;
    assign w_bus.TXchar  = TXchar;
    assign charReady     = w_bus.charReady;
    assign RXchar        = w_bus.RXchar;
    assign TXempty       = w_bus.TXempty;

    rs232_rx #(
        .DIV (DIV)
    ) u_rx (
        .clock (clock),
        .reset (reset),
        .RxD   (RxD),
        .bus   (w_bus.rx)
    );

    rs232_tx #(
        .DIV (DIV)
    ) u_tx (
        .clock (clock),
        .reset (reset),
        .TxD   (TxD),
        .bus   (w_bus.tx)
    );

endmodule

// File: tb/tb_rs232_uart.sv
// Directed bench for rs232_uart at 50 MHz / 115200 baud (434 clocks per bit).
// Drives RxD with its own bit-time model and checks TxD against hand-written frames.
module tb_rs232_uart;

    localparam int DIV  = 434;
    localparam int HALF = 217;
    // Start edge seen after 2 sync flops + 1 FSM cycle, mid-start check, then 9 bit times to stop.
    localparam int RX_LAT = 3 + HALF + 9 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rx_rise  = 0;
    int   low_cnt  = 0;
    logic [9:0] exp_tx;

    rs232_uart_if bus ();

    rs232_uart #(
        .CLK_HZ (50_000_000),
        .BAUD   (115_200)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .RxD       (rxd),
        .readRX    (bus.readRX),
        .charReady (bus.charReady),
        .RXchar    (bus.RXchar),
        .writeTX   (bus.writeTX),
        .TXchar    (bus.TXchar),
        .TXempty   (bus.TXempty),
        .TxD       (txd)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called just after a negedge; edge n of the frame is the n-th posedge that follows.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int rd_at);
        logic [9:0] fr;
        logic       prev;
        fr      = {stop_bit, b, 1'b0};
        prev    = bus.charReady;
        rx_rise = 0;
        for (int n = 1; n <= 10 * DIV; n++) begin
            rxd        = fr[(n - 1) / DIV];
            bus.readRX = (n == rd_at);
            @(negedge clk);
            if (!prev && bus.charReady && rx_rise == 0) rx_rise = n;
            prev = bus.charReady;
        end
        bus.readRX = 1'b0;
        rxd        = stop_bit;
    endtask

    task automatic pulse_read();
        bus.readRX = 1'b1;
        @(negedge clk);
        bus.readRX = 1'b0;
    endtask

    initial begin
        bus.readRX  = 1'b0;
        bus.writeTX = 1'b0;
        bus.TXchar  = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // 1: quiet after reset
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            chk("reset_idle", 32'({txd, bus.TXempty, bus.charReady, bus.RXchar}), 32'({3'b110, 8'h00}));
        end
        $display("reset: 2000 idle cycles observed");

        // 2: receive A5, then consume it
        send_rx(8'hA5, 1'b1, 0);
        chk("rx_a5_latency", 32'(rx_rise), 32'(RX_LAT));
        chk("rx_a5_ready", 32'(bus.charReady), 32'd1);
        chk("rx_a5_char", 32'(bus.RXchar), 32'h A5);
        $display("rx: char %h ready after %0d clocks", bus.RXchar, rx_rise);
        pulse_read();
        chk("rx_read_clear", 32'(bus.charReady), 32'd0);
        chk("rx_read_keep", 32'(bus.RXchar), 32'hA5);

        // 3: transmit 41, second write mid-frame must be ignored
        exp_tx      = 10'b1_0100_0001_0;
        bus.TXchar  = 8'h41;
        bus.writeTX = 1'b1;
        @(negedge clk);
        bus.writeTX = 1'b0;
        chk("tx_start_line", 32'(txd), 32'd0);
        low_cnt = 0;
        for (int j = 0; j < 10 * DIV; j++) begin
            if (!bus.TXempty) low_cnt++;
            if (j % DIV == HALF) chk("tx_41_bit", 32'(txd), 32'(exp_tx[j / DIV]));
            if (j == 2000) begin
                bus.TXchar  = 8'hFF;
                bus.writeTX = 1'b1;
            end else begin
                bus.writeTX = 1'b0;
            end
            @(negedge clk);
        end
        chk("tx_busy_clocks", 32'(low_cnt), 32'd4340);
        chk("tx_empty_again", 32'(bus.TXempty), 32'd1);
        chk("tx_stop_line", 32'(txd), 32'd1);
        repeat (500) @(negedge clk);
        chk("tx_stays_idle", 32'({txd, bus.TXempty}), 32'b11);
        $display("tx: char 41 sent, busy %0d clocks", low_cnt);

        // 4: 100-clock glitch rejected, then 3C
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        rxd = 1'b1;
        repeat (1000) @(negedge clk);
        chk("glitch_no_char", 32'(bus.charReady), 32'd0);
        send_rx(8'h3C, 1'b1, 0);
        chk("rx_3c_latency", 32'(rx_rise), 32'(RX_LAT));
        chk("rx_3c_char", 32'(bus.RXchar), 32'h3C);
        $display("rx: char %h after glitch", bus.RXchar);
        pulse_read();

        // 5: framing error on 55, line held low, then 12
        send_rx(8'h55, 1'b0, 0);
        chk("ferr_ready", 32'(bus.charReady), 32'd0);
        chk("ferr_char_kept", 32'(bus.RXchar), 32'h3C);
        repeat (2000) @(negedge clk);
        chk("break_ready", 32'(bus.charReady), 32'd0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_rx(8'h12, 1'b1, 0);
        chk("rx_12_latency", 32'(rx_rise), 32'(RX_LAT));
        chk("rx_12_char", 32'({bus.charReady, bus.RXchar}), 32'h112);
        $display("rx: char %h after break", bus.RXchar);

        // 6: overrun, read colliding with delivery, reset mid TX frame
        send_rx(8'h01, 1'b1, 0);
        send_rx(8'h02, 1'b1, 0);
        chk("overrun_char", 32'({bus.charReady, bus.RXchar}), 32'h102);
        send_rx(8'h03, 1'b1, RX_LAT);
        chk("collide_char", 32'({bus.charReady, bus.RXchar}), 32'h103);
        $display("rx: char %h delivered alongside read", bus.RXchar);
        pulse_read();
        chk("read_after_collide", 32'(bus.charReady), 32'd0);
        pulse_read();
        chk("read_when_empty", 32'({bus.charReady, bus.RXchar}), 32'h003);

        bus.TXchar  = 8'h00;
        bus.writeTX = 1'b1;
        @(negedge clk);
        bus.writeTX = 1'b0;
        repeat (1000) @(negedge clk);
        chk("tx_mid_frame", 32'({txd, bus.TXempty}), 32'b00);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_tx", 32'({txd, bus.TXempty, bus.charReady, bus.RXchar}), 32'({3'b110, 8'h00}));
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_reset_line", 32'({txd, bus.TXempty}), 32'b11);
        $display("reset: mid-frame abort observed");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
